// File: rtl/register2_load_arbiter.sv
// Round-robin write-port arbiter for the dual-load register. It grants at most one
// writer per cycle, drives registered data and load strobes, and counts contention.
module register2_load_arbiter #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Req1,
  input  logic [WIDTH-1:0]     Data1,
  input  logic                 Req2,
  input  logic [WIDTH-1:0]     Data2,
  input  logic                 Stall,
  output logic                 Ack1,
  output logic                 Ack2,
  output logic [WIDTH-1:0]     IN,
  output logic [WIDTH-1:0]     IN2,
  output logic                 Load,
  output logic                 Load2,
  output logic                 LastGrant,
  output logic [CNT_WIDTH-1:0] Conflicts
);

  // One-hot-style encoding so that each strobe is a bare state flop.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    W1   = 2'b01,
    W2   = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     in_q, in_d;
  logic [WIDTH-1:0]     in2_q, in2_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 e1, e2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      in_q    <= '0;
      in2_q   <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      in2_q   <= in2_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    in_d    = in_q;
    in2_d   = in2_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    // A writer being acknowledged this cycle is masked so it is not granted twice.
    e1      = Req1 && (state_q != W1);
    e2      = Req2 && (state_q != W2);
    if (!Stall) begin
      if (e1 && e2) begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (last_q) begin
          state_d = W1;
          in_d    = Data1;
          last_d  = 1'b0;
        end else begin
          state_d = W2;
          in2_d   = Data2;
          last_d  = 1'b1;
        end
      end else if (e1) begin
        state_d = W1;
        in_d    = Data1;
        last_d  = 1'b0;
      end else if (e2) begin
        state_d = W2;
        in2_d   = Data2;
        last_d  = 1'b1;
      end
    end
  end

  assign Load      = state_q[0];
  assign Ack1      = state_q[0];
  assign Load2     = state_q[1];
  assign Ack2      = state_q[1];
  assign IN        = in_q;
  assign IN2       = in2_q;
  assign LastGrant = last_q;
  assign Conflicts = cnt_q;

endmodule

// File: tb/tb_register2_load_arbiter.sv
// Directed and randomized bench for register2_load_arbiter, checked every cycle
// against a behavioural model (8-bit and 2-bit conflict counter instances).
module tb_register2_load_arbiter;

  logic        Clk = 1'b0;
  logic        Reset, Req1, Req2, Stall;
  logic [31:0] Data1, Data2;

  logic        a1_8, a2_8, l1_8, l2_8, lg_8;
  logic [31:0] in_8, in2_8;
  logic [7:0]  c_8;
  logic        a1_2, a2_2, l1_2, l2_2, lg_2;
  logic [31:0] in_2, in2_2;
  logic [1:0]  c_2;

  int n_checks = 0;
  int n_err    = 0;

  // Model: which writer holds the grant this cycle (0 none, 1, 2).
  int          m_gnt;
  logic [31:0] m_in, m_in2;
  logic        m_last;
  int unsigned m_c8, m_c2;

  always #5 Clk = ~Clk;

  register2_load_arbiter #(.WIDTH(32), .CNT_WIDTH(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Req1(Req1), .Data1(Data1), .Req2(Req2), .Data2(Data2),
    .Stall(Stall), .Ack1(a1_8), .Ack2(a2_8), .IN(in_8), .IN2(in2_8), .Load(l1_8),
    .Load2(l2_8), .LastGrant(lg_8), .Conflicts(c_8)
  );

  register2_load_arbiter #(.WIDTH(32), .CNT_WIDTH(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Req1(Req1), .Data1(Data1), .Req2(Req2), .Data2(Data2),
    .Stall(Stall), .Ack1(a1_2), .Ack2(a2_2), .IN(in_2), .IN2(in2_2), .Load(l1_2),
    .Load2(l2_2), .LastGrant(lg_2), .Conflicts(c_2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit e1, e2;
    int w;
    if (Reset) begin
      m_gnt = 0; m_in = '0; m_in2 = '0; m_last = 1'b1; m_c8 = 0; m_c2 = 0;
      return;
    end
    e1 = Req1 && (m_gnt != 1);
    e2 = Req2 && (m_gnt != 2);
    w  = 0;
    if (!Stall) begin
      if (e1 && e2) begin
        w = m_last ? 1 : 2;
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end else if (e1) w = 1;
      else if (e2) w = 2;
    end
    if (w == 1) begin m_in = Data1; m_last = 1'b0; end
    if (w == 2) begin m_in2 = Data2; m_last = 1'b1; end
    m_gnt = w;
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_edge();
    #1;
    chk("ack1", {31'd0, a1_8}, {31'd0, m_gnt == 1});
    chk("ack2", {31'd0, a2_8}, {31'd0, m_gnt == 2});
    chk("load", {31'd0, l1_8}, {31'd0, m_gnt == 1});
    chk("load2", {31'd0, l2_8}, {31'd0, m_gnt == 2});
    chk("in", in_8, m_in);
    chk("in2", in2_8, m_in2);
    chk("lastgrant", {31'd0, lg_8}, {31'd0, m_last});
    chk("conflicts8", {24'd0, c_8}, m_c8);
    chk("ack1_c2", {31'd0, a1_2}, {31'd0, m_gnt == 1});
    chk("ack2_c2", {31'd0, a2_2}, {31'd0, m_gnt == 2});
    chk("conflicts2", {30'd0, c_2}, m_c2);
  endtask

  initial begin
    int waited;
    Reset = 1'b1; Req1 = 1'b0; Req2 = 1'b0; Stall = 1'b0; Data1 = '0; Data2 = '0;
    m_gnt = 0; m_in = '0; m_in2 = '0; m_last = 1'b1; m_c8 = 0; m_c2 = 0;

    // Reset, then idle
    repeat (2) cycle();
    Reset = 1'b0;
    repeat (5) cycle();
    chk("idle_lastgrant", {31'd0, lg_8}, 32'd1);

    // Single write from writer 1
    Req1 = 1'b1; Data1 = 32'h0000_0005;
    cycle();
    chk("t2_in", in_8, 32'd5);
    chk("t2_load", {31'd0, l1_8}, 32'd1);
    Req1 = 1'b0;
    repeat (2) cycle();
    chk("t2_in_hold", in_8, 32'd5);

    // Both writers held
    Req1 = 1'b1; Req2 = 1'b1; Data1 = 32'd1; Data2 = 32'd2;
    repeat (6) cycle();
    Req1 = 1'b0; Req2 = 1'b0;
    repeat (2) cycle();

    // Writer 2 alone held
    Req2 = 1'b1; Data2 = 32'hABCD_0002;
    repeat (6) cycle();
    Req2 = 1'b0;
    repeat (2) cycle();

    // Stall blocks a pending request
    Req1 = 1'b1; Data1 = 32'h1234_5678; Stall = 1'b1;
    repeat (3) cycle();
    chk("t5_no_ack", {31'd0, a1_8}, 32'd0);
    Stall = 1'b0;
    cycle();
    chk("t5_ack", {31'd0, a1_8}, 32'd1);
    Req1 = 1'b0;
    cycle();

    // Saturation of the 2-bit counter: stall pulses return to IDLE with both eligible
    Req1 = 1'b1; Req2 = 1'b1; Data1 = 32'h11; Data2 = 32'h22;
    for (int i = 0; i < 10; i++) begin
      Stall = (i % 2 == 0);
      cycle();
    end
    Stall = 1'b0;
    chk("t6_sat", {30'd0, c_2}, 32'd3);
    waited = 0;
    while (m_gnt != 2 && waited < 4) begin
      cycle();
      waited++;
    end
    chk("t6_w2_reached", {31'd0, a2_8}, 32'd1);
    Reset = 1'b1;
    cycle();
    chk("t6_rst_ack2", {31'd0, a2_8}, 32'd0);
    chk("t6_rst_cnt", {30'd0, c_2}, 32'd0);
    Reset = 1'b0; Req1 = 1'b0; Req2 = 1'b0;
    cycle();

    // Randomized writers obeying the request/ack protocol
    for (int i = 0; i < 500; i++) begin
      if (Req1 && m_gnt == 1) begin
        Req1 = $urandom_range(0, 1) == 1; Data1 = $urandom;
      end else if (!Req1 && $urandom_range(0, 2) == 0) begin
        Req1 = 1'b1; Data1 = $urandom;
      end else if (Req1 && $urandom_range(0, 15) == 0) Req1 = 1'b0;
      if (Req2 && m_gnt == 2) begin
        Req2 = $urandom_range(0, 1) == 1; Data2 = $urandom;
      end else if (!Req2 && $urandom_range(0, 2) == 0) begin
        Req2 = 1'b1; Data2 = $urandom;
      end else if (Req2 && $urandom_range(0, 15) == 0) Req2 = 1'b0;
      Stall = $urandom_range(0, 3) == 0;
      Reset = $urandom_range(0, 99) == 0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
